// File: rtl/uart_pkg.sv
// uart_pkg: UART frame states, line-idle level and baud/counter sizing helpers.
// Shared by the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with half-bit and full-bit strobes.
// Strobes are decoded from the registered count (no added latency); restart clears it, no backpressure.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == FULL_M1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick = (cnt_q == HALF_M1);
  assign full_tick = (cnt_q == FULL_M1);

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: synchronised UART receiver, mid-bit sampling, stop/parity check, one-word ready/valid output.
// Word valid the cycle after the mid-stop sample and held until rx_ready; a word completing while one is pending is dropped with an overrun pulse. UART_RX_PARITY_EN adds a parity bit.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int IW = cnt_width(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  if ((CLKS_PER_BIT < 4) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
      (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
    $error("uart_rx_framed: unsupported CLK_HZ/BAUD, DATA_BITS or PARITY_ODD");
  end

  logic                 sync1_q, sync2_q, rx_s;
  uart_state_e          state_q, state_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 half_tick, full_tick, timer_restart;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_err_q, par_bit_err_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign rx_s = sync2_q;

  // Hold the bit timer at zero while idle and realign it to the middle of the start bit.
  assign timer_restart = (state_q == IDLE) || ((state_q == START) && half_tick);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (timer_restart),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_err_d = par_bit_err_q;
    parity_err_d  = parity_err_q;
`endif

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_enable && (rx_s != LINE_IDLE)) begin
          state_d = START;
        end
      end
      START: begin
        if (half_tick) begin
          if (rx_s == LINE_IDLE) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + IW'(1);
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_tick) begin
          par_bit_err_d = ((^shift_q) ^ rx_s) != PARITY_ODD[0];
          state_d       = STOP;
        end
      end
`endif
      STOP: begin
        if (full_tick) begin
          state_d = IDLE;
          if (!rx_valid_q || rx_ready) begin
            rx_data_d   = shift_q;
            frame_err_d = ~rx_s;
            rx_valid_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bit_err_q;
`endif
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= LINE_IDLE;
      sync2_q     <= LINE_IDLE;
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_err_q <= par_bit_err_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: table vectors, hand corner sequences and random frames against a word-level model.
module tb_uart_rx_framed;

  localparam int CLK_HZ     = 12000000;
  localparam int BAUD       = 115200;
  localparam int DATA_BITS  = 8;
  localparam int PARITY_ODD = 0;
  localparam int CLKS       = CLK_HZ / BAUD;
  localparam int HALF       = CLKS / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Negedges from the start edge to rx_valid: 2 sync flops + 1 detect cycle, half a bit,
  // then every data bit, the parity bit if present and the stop bit.
  localparam int LAT_EXP = 3 + HALF + (DATA_BITS + (PAR_EN ? 1 : 0) + 1) * CLKS;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } word_t;

  typedef struct {
    logic [7:0] d;
    logic       stop_b;
    logic       par_b;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int    vectors     = 0;
  int    miscompares = 0;
  int    ovr_cycles  = 0;
  word_t got_q[$];
  word_t exp_q[$];

  uart_rx_framed #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_enable (rx_enable),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Consumer-side observer: records every accepted word and every overrun cycle.
  always @(negedge clk) begin
    #1;
    if (rx_valid && rx_ready) got_q.push_back({rx_data, frame_err, parity_err});
    if (overrun) ovr_cycles++;
  end

  initial begin
    repeat (95000) @(negedge clk);
    $display("FAIL watchdog: simulation exceeded 95000 cycles, required completion earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_pe(input logic [7:0] d, input logic par_b);
    if (!PAR_EN) return 1'b0;
    return ((($countones(d) + int'(par_b)) % 2) != PARITY_ODD);
  endfunction

  // Caller is at a negedge; every line bit lasts CLKS cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int gap);
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      repeat (CLKS) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par_b;
      repeat (CLKS) @(negedge clk);
    end
    rx = stop_b;
    repeat (CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_word(input string name, input word_t exp);
    word_t w;
    check({name, " count"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      check({name, " data"}, 32'(w.d), 32'(exp.d));
      check({name, " frame_err"}, 32'(w.fe), 32'(exp.fe));
      check({name, " parity_err"}, 32'(w.pe), 32'(exp.pe));
    end
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " rx_valid"}, 32'(rx_valid), 32'd0);
    check({name, " rx_data"}, 32'(rx_data), 32'd0);
    check({name, " frame_err"}, 32'(frame_err), 32'd0);
    check({name, " parity_err"}, 32'(parity_err), 32'd0);
    check({name, " overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    vec_t       tbl[8];
    int         lat;
    int         ovr0;
    logic [7:0] rd;
    logic       rs, rp;
    int         rg;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
    tbl[3] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[4] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1};
    tbl[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};

    rst_n = 1'b0; rx = 1'b1; rx_enable = 1'b1; rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First-word latency and single-cycle valid with rx_ready high.
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 20);
      begin
        while (rx_valid !== 1'b1 && lat < LAT_EXP + 200) begin
          @(negedge clk);
          lat++;
        end
        check("latency", 32'(lat), 32'(LAT_EXP));
        @(negedge clk);
        check("valid drop after accept", 32'(rx_valid), 32'd0);
      end
    join
    expect_word("first A5", '{8'hA5, 1'b0, 1'b0});

    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].d, tbl[i].stop_b, tbl[i].par_b, 24);
      expect_word($sformatf("tbl[%0d]", i),
                  '{tbl[i].exp_d, tbl[i].exp_fe, PAR_EN ? tbl[i].exp_pe : 1'b0});
    end

    // Short low pulse is rejected, then a real frame is still received.
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    check("glitch no word", 32'(got_q.size()), 32'd0);
    check("glitch rx_valid", 32'(rx_valid), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 24);
    expect_word("after glitch", '{8'h3C, 1'b0, 1'b0});

    rx_enable = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 24);
    check("disabled no word", 32'(got_q.size()), 32'd0);
    rx_enable = 1'b1;
    fork
      send_frame(8'h96, 1'b1, 1'b0, 24);
      begin
        repeat (300) @(negedge clk);
        rx_enable = 1'b0;
      end
    join
    expect_word("enable drop mid-frame", '{8'h96, 1'b0, model_pe(8'h96, 1'b0)});
    rx_enable = 1'b1;

    // Overrun: second word arrives while the first is still pending.
    rx_ready = 1'b0;
    ovr0 = ovr_cycles;
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 24);
    check("overrun pulse cycles", 32'(ovr_cycles - ovr0), 32'd1);
    check("overrun held valid", 32'(rx_valid), 32'd1);
    check("overrun held data", 32'(rx_data), 32'h11);
    check("overrun no accept", 32'(got_q.size()), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    #2;
    check("overrun valid after accept", 32'(rx_valid), 32'd0);
    expect_word("overrun kept word", '{8'h11, 1'b0, 1'b0});

    // Reset in the middle of data bit 4 abandons the frame.
    fork
      send_frame(8'hF0, 1'b1, 1'b0, 24);
      begin
        repeat (5 * CLKS + HALF) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("mid-frame reset");
        rst_n = 1'b1;
      end
    join
    check("no partial word", 32'(got_q.size()), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 24);
    expect_word("after reset", '{8'h81, 1'b0, 1'b0});

    // Random frames, mixed gaps (including back-to-back) and occasional bad stop bits.
    ovr0 = ovr_cycles;
    exp_q.delete();
    got_q.delete();
    for (int n = 0; n < 24; n++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      rp = 1'($urandom);
      rg = rs ? $urandom_range(0, 30) : $urandom_range(4, 30);
      exp_q.push_back('{rd, ~rs, model_pe(rd, rp)});
      send_frame(rd, rs, rp, rg);
    end
    repeat (50) @(negedge clk);
    check("random word count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("random[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check("random no overrun", 32'(ovr_cycles - ovr0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
